// File: rtl/uart_char_tx.sv
// uart_char_tx: 8N1 UART serializer for a character stream, with optional LF -> CR LF expansion
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   char_in    : character byte from upstream
//   char_valid : char_in holds a character to send
//   char_ready : block accepts a character this cycle
//   crlf_en    : expand LF into CR LF, sampled at accept
//   tx         : UART serial line, idle high, registered
//   busy       : a character (one or two frames) is in flight
//   frame_done : one-cycle pulse in the last cycle of each stop bit
module uart_char_tx #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   input  logic       crlf_en,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, IDLE_INT} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          lf_pend_q, lf_pend_d;
   logic          tx_q, tx_d;
   logic          bit_end, accept, is_lf;
   assign bit_end    = cnt_q == CNT_MAX;
   assign char_ready = state_q == IDLE && !reset;
   assign accept     = char_valid && char_ready;
   assign is_lf      = crlf_en && char_in == 8'h0A;
   assign busy       = state_q != IDLE;
   assign frame_done = state_q == STOP && bit_end;
   assign tx         = tx_q;
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      lf_pend_d = lf_pend_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d   = START;
            shift_d   = is_lf ? 8'h0D : char_in;
            lf_pend_d = is_lf;
            idx_d     = '0;
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == 3'd7) state_d = STOP;
         end
         STOP: if (bit_end) begin
            state_d = lf_pend_q ? IDLE_INT : IDLE;
            if (lf_pend_q) begin
               shift_d   = 8'h0A;
               lf_pend_d = 1'b0;
            end
         end
         IDLE_INT: state_d = START;
         default:  state_d = IDLE;
      endcase
      // counter restarts on every state change so bit timing never drifts
      cnt_d = (state_d != state_q || bit_end || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      // tx is registered from the next-cycle state so the line is glitch-free
      tx_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         lf_pend_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         lf_pend_q <= lf_pend_d;
         tx_q      <= tx_d;
      end
   end
endmodule
